// File: rtl/mcpu_control_fsm_pkg.sv
// Shared types for the MCPU control sequencer: state encodings, opcode/funct
// codes, ALU operations, datapath mux selects and the per-state control word.
package mcpu_pkg;

  typedef enum logic [5:0] {
    S_FETCH    = 6'd0,
    S_DECODE   = 6'd1,
    S_EXEC_R   = 6'd2,
    S_RWB_R    = 6'd3,
    S_EXEC_I   = 6'd4,
    S_RWB_I    = 6'd5,
    S_MEM_ADDR = 6'd6,
    S_MEM_RD   = 6'd7,
    S_MEM_WB   = 6'd8,
    S_MEM_WR   = 6'd9,
    S_BRANCH   = 6'd10,
    S_JUMP     = 6'd11,
    S_JR       = 6'd12,
    S_HALT     = 6'd63
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SLT = 3'b011
  } aluop_t;

  typedef enum logic [1:0] {SRCA_PC, SRCA_A, SRCA_BEN, SRCA_ZERO} srca_t;
  typedef enum logic [1:0] {SRCB_IMM_SH2, SRCB_IMM, SRCB_B, SRCB_FOUR} srcb_t;
  typedef enum logic [1:0] {PCSRC_BRANCH, PCSRC_JUMP, PCSRC_ALU_OUT, PCSRC_ALU_REG} pcsrc_t;

  typedef struct packed {
    logic   pc_we;
    logic   ir_we;
    logic   a_we;
    logic   b_we;
    logic   ben;
    logic   mem_we;
    logic   reg_we;
    logic   memin;
    logic   dst;
    logic   regin;
    logic   jal;
    srca_t  alusrca;
    srcb_t  alusrcb;
    aluop_t aluop;
    pcsrc_t pcsrc;
  } ctrl_t;

  typedef struct packed {
    state_t next;
    logic   illegal;
    aluop_t aluop;
    logic   is_load;
    logic   is_bne;
    logic   is_jal;
  } decode_t;

  // Moore control word for a state; the BRANCH pc_we is added outside.
  function automatic ctrl_t ctrl_of(input state_t s, input aluop_t op, input logic link);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_we   = 1'b1;
        c.alusrca = SRCA_PC;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALU_ADD;
        c.pcsrc   = PCSRC_ALU_OUT;
        c.pc_we   = 1'b1;
      end
      S_DECODE: begin
        c.a_we    = 1'b1;
        c.b_we    = 1'b1;
        c.alusrca = SRCA_PC;
        c.alusrcb = SRCB_IMM_SH2;
        c.aluop   = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alusrca = SRCA_A;
        c.alusrcb = SRCB_B;
        c.aluop   = op;
      end
      S_RWB_R: begin
        c.reg_we = 1'b1;
        c.regin  = 1'b1;
      end
      S_EXEC_I: begin
        c.alusrca = SRCA_A;
        c.alusrcb = SRCB_IMM;
        c.aluop   = op;
      end
      S_RWB_I: begin
        c.reg_we = 1'b1;
        c.dst    = 1'b1;
        c.regin  = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alusrca = SRCA_A;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
      end
      S_MEM_RD: c.memin = 1'b1;
      S_MEM_WB: begin
        c.reg_we = 1'b1;
        c.dst    = 1'b1;
      end
      S_MEM_WR: begin
        c.memin  = 1'b1;
        c.mem_we = 1'b1;
      end
      S_BRANCH: begin
        c.ben     = 1'b1;
        c.alusrca = SRCA_A;
        c.alusrcb = SRCB_B;
        c.aluop   = ALU_SUB;
        c.pcsrc   = PCSRC_ALU_REG;
      end
      S_JUMP: begin
        c.pcsrc  = PCSRC_JUMP;
        c.pc_we  = 1'b1;
        c.jal    = link;
        c.reg_we = link;
      end
      // JR relies on the datapath zeroing the immediate so the ALU passes A.
      S_JR: begin
        c.alusrca = SRCA_A;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
        c.pcsrc   = PCSRC_ALU_OUT;
        c.pc_we   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcpu_control_fsm_if.sv
// Control bundle between the MCPU sequencer (master) and its datapath (slave).
interface mcpu_control_fsm_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               pc_we;
  logic               ir_we;
  logic               a_we;
  logic               b_we;
  logic               ben;
  logic               mem_we;
  logic               reg_we;
  logic               memin;
  logic               dst;
  logic               regin;
  logic               jal;
  logic [1:0]         alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         aluop;
  logic [1:0]         pcsrc;
  logic [5:0]         state;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero,
    output pc_we, ir_we, a_we, b_we, ben, mem_we, reg_we,
           memin, dst, regin, jal, alusrca, alusrcb, aluop, pcsrc,
           state, halted, instr_count
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, ir_we, a_we, b_we, ben, mem_we, reg_we,
           memin, dst, regin, jal, alusrca, alusrcb, aluop, pcsrc,
           state, halted, instr_count
  );
endinterface

// File: rtl/mcpu_control_fsm_decode.sv
// Opcode/funct decoder choosing the state that follows DECODE, plus the
// per-instruction flags the sequencer needs later in the instruction.
module mcpu_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec
);

  // Anything not matched below falls through to HALT with illegal set.
  always_comb begin
    dec         = '0;
    dec.next    = S_HALT;
    dec.illegal = 1'b1;
    dec.aluop   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin dec.next = S_EXEC_R; dec.aluop = ALU_ADD; dec.illegal = 1'b0; end
          FN_SUB: begin dec.next = S_EXEC_R; dec.aluop = ALU_SUB; dec.illegal = 1'b0; end
          FN_SLT: begin dec.next = S_EXEC_R; dec.aluop = ALU_SLT; dec.illegal = 1'b0; end
          FN_JR:  begin dec.next = S_JR;     dec.illegal = 1'b0; end
          default: begin dec.next = S_HALT; dec.illegal = 1'b1; end
        endcase
      end
      OP_ADDI: begin dec.next = S_EXEC_I; dec.aluop = ALU_ADD; dec.illegal = 1'b0; end
      OP_XORI: begin dec.next = S_EXEC_I; dec.aluop = ALU_XOR; dec.illegal = 1'b0; end
      OP_LW:   begin dec.next = S_MEM_ADDR; dec.is_load = 1'b1; dec.illegal = 1'b0; end
      OP_SW:   begin dec.next = S_MEM_ADDR; dec.illegal = 1'b0; end
      OP_BEQ:  begin dec.next = S_BRANCH; dec.illegal = 1'b0; end
      OP_BNE:  begin dec.next = S_BRANCH; dec.is_bne = 1'b1; dec.illegal = 1'b0; end
      OP_J:    begin dec.next = S_JUMP; dec.illegal = 1'b0; end
      OP_JAL:  begin dec.next = S_JUMP; dec.is_jal = 1'b1; dec.illegal = 1'b0; end
      default: begin dec.next = S_HALT; dec.illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/mcpu_control_fsm.sv
// Multi-cycle MCPU control sequencer: Moore FSM with registered control word,
// retired-instruction counter and sticky halt on illegal instructions.
module mcpu_control_fsm
  import mcpu_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  mcpu_control_fsm_if.master  bus
);

  state_t             state;
  ctrl_t              ctrl_q;
  logic               is_load_q;
  logic               is_bne_q;
  logic               halted_q;
  logic [COUNT_W-1:0] count_q;
  decode_t            dec;

  mcpu_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .dec    (dec)
  );

  // The control word is computed for the state being entered, so outputs are
  // valid from the edge that enters each state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH, ALU_ADD, 1'b0);
      is_load_q <= 1'b0;
      is_bne_q  <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          state  <= S_DECODE;
          ctrl_q <= ctrl_of(S_DECODE, ALU_ADD, 1'b0);
        end
        S_DECODE: begin
          state     <= dec.next;
          ctrl_q    <= ctrl_of(dec.next, dec.aluop, dec.is_jal);
          is_load_q <= dec.is_load;
          is_bne_q  <= dec.is_bne;
          if (dec.illegal) halted_q <= 1'b1;
        end
        S_EXEC_R: begin
          state  <= S_RWB_R;
          ctrl_q <= ctrl_of(S_RWB_R, ALU_ADD, 1'b0);
        end
        S_EXEC_I: begin
          state  <= S_RWB_I;
          ctrl_q <= ctrl_of(S_RWB_I, ALU_ADD, 1'b0);
        end
        S_MEM_ADDR: begin
          state  <= is_load_q ? S_MEM_RD : S_MEM_WR;
          ctrl_q <= ctrl_of(is_load_q ? S_MEM_RD : S_MEM_WR, ALU_ADD, 1'b0);
        end
        S_MEM_RD: begin
          state  <= S_MEM_WB;
          ctrl_q <= ctrl_of(S_MEM_WB, ALU_ADD, 1'b0);
        end
        S_RWB_R, S_RWB_I, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR: begin
          state   <= S_FETCH;
          ctrl_q  <= ctrl_of(S_FETCH, ALU_ADD, 1'b0);
          count_q <= count_q + COUNT_W'(1);
        end
        S_HALT: begin
          state  <= S_HALT;
          ctrl_q <= ctrl_of(S_HALT, ALU_ADD, 1'b0);
        end
        default: begin
          state  <= S_FETCH;
          ctrl_q <= ctrl_of(S_FETCH, ALU_ADD, 1'b0);
        end
      endcase
    end
  end

  // BEQ takes the branch on zero, BNE on not-zero, within the BRANCH cycle.
  assign bus.pc_we       = ctrl_q.pc_we | ((state == S_BRANCH) & (bus.zero ^ is_bne_q));
  assign bus.ir_we       = ctrl_q.ir_we;
  assign bus.a_we        = ctrl_q.a_we;
  assign bus.b_we        = ctrl_q.b_we;
  assign bus.ben         = ctrl_q.ben;
  assign bus.mem_we      = ctrl_q.mem_we;
  assign bus.reg_we      = ctrl_q.reg_we;
  assign bus.memin       = ctrl_q.memin;
  assign bus.dst         = ctrl_q.dst;
  assign bus.regin       = ctrl_q.regin;
  assign bus.jal         = ctrl_q.jal;
  assign bus.alusrca     = ctrl_q.alusrca;
  assign bus.alusrcb     = ctrl_q.alusrcb;
  assign bus.aluop       = ctrl_q.aluop;
  assign bus.pcsrc       = ctrl_q.pcsrc;
  assign bus.state       = state;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Randomized self-checking bench for mcpu_control_fsm against a per-instruction
// phase model built from the instruction set and its CPI table.
module tb_mcpu_control_fsm;
  import mcpu_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic [5:0] state;
    logic       pc_we;
    logic       ir_we;
    logic       a_we;
    logic       b_we;
    logic       ben;
    logic       mem_we;
    logic       reg_we;
    logic       memin;
    logic       dst;
    logic       regin;
    logic       jal;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       halted;
  } view_t;

  localparam logic [5:0] OP_TAB [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E,
                                         6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  localparam logic [5:0] FN_TAB [4]  = '{6'h20, 6'h22, 6'h2A, 6'h08};

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  int   model_count = 0;
  int   zero_mode = -1;

  mcpu_control_fsm_if #(.COUNT_W(CW)) bus ();

  mcpu_control_fsm #(.COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic view_t observe();
    view_t v;
    v.state   = bus.state;
    v.pc_we   = bus.pc_we;
    v.ir_we   = bus.ir_we;
    v.a_we    = bus.a_we;
    v.b_we    = bus.b_we;
    v.ben     = bus.ben;
    v.mem_we  = bus.mem_we;
    v.reg_we  = bus.reg_we;
    v.memin   = bus.memin;
    v.dst     = bus.dst;
    v.regin   = bus.regin;
    v.jal     = bus.jal;
    v.alusrca = bus.alusrca;
    v.alusrcb = bus.alusrcb;
    v.aluop   = bus.aluop;
    v.pcsrc   = bus.pcsrc;
    v.halted  = bus.halted;
    return v;
  endfunction

  // Expected outputs for one phase, written straight from the state descriptions.
  function automatic view_t expect_view(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z);
    view_t v;
    v = '0;
    v.state = s;
    case (s)
      S_FETCH:    begin v.ir_we = 1; v.alusrcb = 2'd3; v.pcsrc = 2'd2; v.pc_we = 1; end
      S_DECODE:   begin v.a_we = 1; v.b_we = 1; end
      S_EXEC_R:   begin
        v.alusrca = 2'd1; v.alusrcb = 2'd2;
        v.aluop = (fn == 6'h22) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
      end
      S_RWB_R:    begin v.reg_we = 1; v.regin = 1; end
      S_EXEC_I:   begin v.alusrca = 2'd1; v.alusrcb = 2'd1; v.aluop = (op == 6'h0E) ? 3'b010 : 3'b000; end
      S_RWB_I:    begin v.reg_we = 1; v.dst = 1; v.regin = 1; end
      S_MEM_ADDR: begin v.alusrca = 2'd1; v.alusrcb = 2'd1; end
      S_MEM_RD:   v.memin = 1;
      S_MEM_WB:   begin v.reg_we = 1; v.dst = 1; end
      S_MEM_WR:   begin v.memin = 1; v.mem_we = 1; end
      S_BRANCH:   begin
        v.ben = 1; v.alusrca = 2'd1; v.alusrcb = 2'd2; v.aluop = 3'b001; v.pcsrc = 2'd3;
        v.pc_we = (op == 6'h04) ? z : ~z;
      end
      S_JUMP:     begin v.pcsrc = 2'd1; v.pc_we = 1; v.jal = (op == 6'h03); v.reg_we = (op == 6'h03); end
      S_JR:       begin v.alusrca = 2'd1; v.alusrcb = 2'd1; v.pcsrc = 2'd2; v.pc_we = 1; end
      S_HALT:     v.halted = 1;
      default:    v = '0;
    endcase
    return v;
  endfunction

  // Phase list of one instruction; its length is the instruction's CPI.
  function automatic int plan(input logic [5:0] op, input logic [5:0] fn, output state_t seq [5]);
    int n;
    for (int i = 0; i < 5; i++) seq[i] = S_FETCH;
    seq[1] = S_DECODE;
    seq[2] = S_HALT;
    n = 3;
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) begin seq[2] = S_EXEC_R; seq[3] = S_RWB_R; n = 4; end
        else if (fn == 6'h08) seq[2] = S_JR;
      end
      6'h08, 6'h0E: begin seq[2] = S_EXEC_I; seq[3] = S_RWB_I; n = 4; end
      6'h23: begin seq[2] = S_MEM_ADDR; seq[3] = S_MEM_RD; seq[4] = S_MEM_WB; n = 5; end
      6'h2B: begin seq[2] = S_MEM_ADDR; seq[3] = S_MEM_WR; n = 4; end
      6'h04, 6'h05: seq[2] = S_BRANCH;
      6'h02, 6'h03: seq[2] = S_JUMP;
      default: seq[2] = S_HALT;
    endcase
    return n;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
    if (zero_mode < 0) bus.zero = 1'($urandom_range(0, 1));
    else bus.zero = (zero_mode != 0);
    #1;
  endtask

  task automatic check_cycle(input string tag, input state_t s);
    check_output({tag, "/view"}, 64'(observe()), 64'(expect_view(s, bus.opcode, bus.funct, bus.zero)));
    check_output({tag, "/count"}, 64'(bus.instr_count), 64'(model_count));
  endtask

  task automatic apply_stimulus(input string name, input logic [5:0] op, input logic [5:0] fn, input int hold);
    state_t seq [5];
    int     n;
    bus.opcode = op;
    bus.funct  = fn;
    n = plan(op, fn, seq);
    for (int i = 0; i < n; i++) begin
      if (i > 0) advance();
      check_cycle($sformatf("%s.p%0d", name, i), seq[i]);
    end
    if (seq[n-1] == S_HALT) begin
      for (int i = 0; i < hold; i++) begin
        advance();
        check_cycle($sformatf("%s.hold%0d", name, i), S_HALT);
      end
    end else begin
      advance();
      model_count = (model_count + 1) % (1 << CW);
      check_cycle($sformatf("%s.retire", name), S_FETCH);
    end
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    model_count = 0;
    check_cycle({name, ".hold"}, S_FETCH);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_cycle({name, ".rel"}, S_FETCH);
  endtask

  initial begin
    int         idx;
    logic [5:0] op;
    logic [5:0] fn;
    reset      = 1'b0;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;
    #2;
    do_reset("rst0");

    apply_stimulus("add",  6'h00, 6'h20, 0);
    apply_stimulus("lw",   6'h23, 6'h11, 0);
    apply_stimulus("sw",   6'h2B, 6'h05, 0);
    apply_stimulus("addi", 6'h08, 6'h3F, 0);
    apply_stimulus("xori", 6'h0E, 6'h00, 0);
    apply_stimulus("sub",  6'h00, 6'h22, 0);
    apply_stimulus("slt",  6'h00, 6'h2A, 0);
    apply_stimulus("jr",   6'h00, 6'h08, 0);
    zero_mode = 1; apply_stimulus("beq_z1", 6'h04, 6'h00, 0);
    zero_mode = 0; apply_stimulus("beq_z0", 6'h04, 6'h00, 0);
    zero_mode = 1; apply_stimulus("bne_z1", 6'h05, 6'h00, 0);
    zero_mode = 0; apply_stimulus("bne_z0", 6'h05, 6'h00, 0);
    zero_mode = -1;
    apply_stimulus("j",   6'h02, 6'h12, 0);
    apply_stimulus("jal", 6'h03, 6'h07, 0);

    // Abort an LW in MEM_RD: no write-back, count cleared.
    bus.opcode = 6'h23;
    bus.funct  = 6'h00;
    check_cycle("abort.p0", S_FETCH);
    advance(); check_cycle("abort.p1", S_DECODE);
    advance(); check_cycle("abort.p2", S_MEM_ADDR);
    advance(); check_cycle("abort.p3", S_MEM_RD);
    reset = 1'b1;
    #1;
    model_count = 0;
    check_cycle("abort.rst", S_FETCH);
    @(posedge clk);
    #2;
    check_cycle("abort.rst_edge", S_FETCH);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_cycle("abort.rel", S_FETCH);

    for (int k = 0; k < 16; k++) apply_stimulus($sformatf("wrap%0d", k), 6'h02, 6'h00, 0);

    for (int k = 0; k < 40; k++) begin
      idx = int'($urandom_range(0, 11));
      op  = OP_TAB[idx];
      fn  = (idx < 4) ? FN_TAB[idx] : 6'($urandom);
      apply_stimulus($sformatf("rnd%0d", k), op, fn, 0);
    end

    apply_stimulus("ill_op", 6'h3F, 6'h20, 100);
    do_reset("rst1");
    apply_stimulus("ill_fn", 6'h00, 6'h3F, 20);
    do_reset("rst2");
    apply_stimulus("add2", 6'h00, 6'h20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
